// File: rtl/ysyx_22050133_div_arbiter.sv
// Two-requester front end for the shared iterative 64-bit divider: round-robin grant,
// local divide-by-zero / signed-overflow results, divider handshake sequencing and per-owner flush.
`timescale 1ns/1ps
module ysyx_22050133_div_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req0_valid,
    output logic        o_req0_ready,
    input  logic [2:0]  i_req0_op,
    input  logic [63:0] i_req0_a,
    input  logic [63:0] i_req0_b,
    input  logic        i_req0_flush,
    input  logic        i_req1_valid,
    output logic        o_req1_ready,
    input  logic [2:0]  i_req1_op,
    input  logic [63:0] i_req1_a,
    input  logic [63:0] i_req1_b,
    input  logic        i_req1_flush,
    output logic        o_resp0_valid,
    input  logic        i_resp0_ready,
    output logic [63:0] o_resp0_data,
    output logic        o_resp1_valid,
    input  logic        i_resp1_ready,
    output logic [63:0] o_resp1_data,
    output logic        o_dv_valid,
    output logic        o_dv_divw,
    output logic        o_dv_signed,
    output logic        o_dv_flush,
    output logic [63:0] o_dv_dividend,
    output logic [63:0] o_dv_divisor,
    input  logic        i_dv_ready,
    input  logic        i_dv_out_valid,
    input  logic [63:0] i_dv_quotient,
    input  logic [63:0] i_dv_remainder,
    output logic [1:0]  o_state
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2, S_RESP = 2'd3} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_rr_ptr;
    logic        r_owner;
    logic [2:0]  r_op;
    logic [63:0] r_a;
    logic [63:0] r_b;
    logic [63:0] r_result;

    logic        w_grant;
    logic        w_idle;
    logic        w_accept;
    logic [2:0]  w_op;
    logic [63:0] w_a;
    logic [63:0] w_b;
    logic        w_word;
    logic        w_div0;
    logic        w_ovf;
    logic        w_special;
    logic [63:0] w_spec_raw;
    logic [63:0] w_spec_res;
    logic [63:0] w_dv_raw;
    logic [63:0] w_dv_res;
    logic        w_own_flush;
    logic        w_own_ready;
    logic        w_in_div;

    assign w_grant      = (i_req0_valid & i_req1_valid) ? r_rr_ptr : i_req1_valid;
    // Ready stays low while reset is held so nothing is offered before the block is live.
    assign w_idle       = (r_state == S_IDLE) & rst_n;
    assign o_req0_ready = w_idle & ~w_grant & ~i_req0_flush;
    assign o_req1_ready = w_idle &  w_grant & ~i_req1_flush;
    assign w_accept     = (o_req0_ready & i_req0_valid) | (o_req1_ready & i_req1_valid);

    assign w_op   = w_grant ? i_req1_op : i_req0_op;
    assign w_a    = w_grant ? i_req1_a  : i_req0_a;
    assign w_b    = w_grant ? i_req1_b  : i_req0_b;
    assign w_word = w_op[2];

    // Cases the divider never sees; results follow the RISC-V M-extension rules.
    assign w_div0 = w_word ? (w_b[31:0] == 32'd0) : (w_b == 64'd0);
    assign w_ovf  = ~w_op[0] & (w_word
                    ? ((w_a[31:0] == 32'h8000_0000) && (w_b[31:0] == 32'hFFFF_FFFF))
                    : ((w_a == 64'h8000_0000_0000_0000) && (w_b == 64'hFFFF_FFFF_FFFF_FFFF)));
    assign w_special  = w_div0 | w_ovf;
    assign w_spec_raw = w_div0 ? (w_op[1] ? w_a : 64'hFFFF_FFFF_FFFF_FFFF)
                               : (w_op[1] ? 64'd0 : w_a);
    assign w_spec_res = w_word ? {{32{w_spec_raw[31]}}, w_spec_raw[31:0]} : w_spec_raw;

    assign w_dv_raw = r_op[1] ? i_dv_remainder : i_dv_quotient;
    assign w_dv_res = r_op[2] ? {{32{w_dv_raw[31]}}, w_dv_raw[31:0]} : w_dv_raw;

    assign w_own_flush = r_owner ? i_req1_flush  : i_req0_flush;
    assign w_own_ready = r_owner ? i_resp1_ready : i_resp0_ready;
    assign w_in_div    = (r_state == S_ISSUE) | (r_state == S_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = w_special ? S_RESP : S_ISSUE;
            S_ISSUE: if (w_own_flush) w_next = S_IDLE;
                     else if (i_dv_ready) w_next = S_WAIT;
            // dv_out_valid is only looked at here, so a stale post-flush pulse is harmless.
            S_WAIT:  if (w_own_flush) w_next = S_IDLE;
                     else if (i_dv_out_valid) w_next = S_RESP;
            S_RESP:  if (w_own_flush | w_own_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= 1'b0;
            r_owner  <= 1'b0;
            r_op     <= 3'd0;
            r_a      <= 64'd0;
            r_b      <= 64'd0;
            r_result <= 64'd0;
        end else begin
            if (w_accept) begin
                r_owner  <= w_grant;
                r_rr_ptr <= ~w_grant;
                r_op     <= w_op;
                r_a      <= w_a;
                r_b      <= w_b;
                if (w_special) r_result <= w_spec_res;
            end
            if ((r_state == S_WAIT) && !w_own_flush && i_dv_out_valid)
                r_result <= w_dv_res;
        end
    end

    assign o_dv_valid    = (r_state == S_ISSUE) & ~w_own_flush;
    assign o_dv_flush    = w_in_div & w_own_flush;
    assign o_dv_divw     = (r_state == S_ISSUE) & r_op[2];
    assign o_dv_signed   = (r_state == S_ISSUE) & ~r_op[0];
    assign o_dv_dividend = r_a;
    assign o_dv_divisor  = r_b;

    assign o_resp0_valid = (r_state == S_RESP) & ~r_owner & ~i_req0_flush;
    assign o_resp1_valid = (r_state == S_RESP) &  r_owner & ~i_req1_flush;
    assign o_resp0_data  = r_result;
    assign o_resp1_data  = r_result;
    assign o_state       = r_state;
endmodule

// File: doc/ysyx_22050133_div_arbiter.md
# ysyx_22050133_div_arbiter

Shares the single iterative 64-bit divider between two requesters (EXU integer pipe on port 0, a second issue slot or coprocessor on port 1). Accepts RISC-V M-extension divide/remainder ops and arbitrates them round-robin. It resolves divide-by-zero and signed-overflow cases locally without occupying the divider, and sequences the divider's valid/ready/out_valid handshake. It returns a final, RISC-V-correct 64-bit result to the owning requester and handles per-requester flush.

## Interface
- XLEN, 64, operand/result width; only 64 is supported.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- reqN_valid / reqN_ready (N=0,1)  in / out  1  op request handshake; accepted on a cycle where both are high.
- reqN_op  in  3  [2]=word (W form), [1]=remainder (0 selects quotient), [0]=unsigned.
- reqN_a / reqN_b  in  64  dividend / divisor.
- reqN_flush  in  1  cancels requester N's outstanding op.
- respN_valid / respN_ready  out / in  1  result handshake.
- respN_data  out  64  result.
- dv_valid, dv_divw, dv_signed, dv_flush  out  1  divider controls.
- dv_dividend, dv_divisor  out  64  divider operands.
- dv_ready, dv_out_valid  in  1  divider idle / result valid; dv_out_valid is sticky until the divider's next accept.
- dv_quotient, dv_remainder  in  64  divider results.

## Operation
- **States:** IDLE, ISSUE, WAIT, RESP. One op is in flight at most.
- **IDLE:** grant = requester with valid. If both are valid, the one selected by rr_ptr wins. reqN_ready = IDLE & grant==N & ~reqN_flush. On accept, register op, operands and owner, then set rr_ptr = ~owner.
- **Special case on accept** (computed from request inputs, word forms use bits [31:0]). Go directly to RESP with the result registered:
  - divisor==0: quotient = all ones, remainder = dividend.
  - Signed, dividend==most-negative (64- or 32-bit), divisor==-1: quotient = dividend, remainder = 0.
- **Otherwise go to ISSUE.** dv_valid=1 with registered operands, dv_divw=op[2], dv_signed=~op[0]. When dv_ready is high at the edge, go to WAIT.
- **WAIT:** dv_out_valid is sampled only in WAIT. When it is 1, capture dv_remainder if op[1] else dv_quotient, and go to RESP.
- **Word forms:** the result is always sign-extended from bit 31, including DIVUW/REMUW.
- **RESP:** respN_valid=1 for the owner with data stable. When respN_ready is high, go to IDLE. A new accept is possible the next cycle; there is no accept in the same cycle.
- **Flush by owner:**
  - In ISSUE or WAIT: dv_flush=1 combinationally that cycle, dv_valid forced 0, next state IDLE. The divider's spurious post-flush dv_out_valid is ignored, since it is only sampled in WAIT.
  - In RESP: the response is dropped, next state IDLE.
  - Flush by the non-owner has no effect.
- dv_valid, respN_valid and reqN_ready are never high outside their states.

## Timing
- **Reset** (rst_n low, asynchronous): state=IDLE, rr_ptr=0, all registered outputs 0. reqN_ready follows IDLE once rst_n deasserts.
- **Special case:** accept at edge t, respN_valid high in cycle t+1. dv_valid is never asserted.
- **Normal op:**
  - Accept edge t; dv_valid high in cycle t+1, held until dv_ready is sampled high.
  - In WAIT, the result is captured on the first edge with dv_out_valid=1; respN_valid is high the following cycle.
  - End-to-end latency is divider latency + 2 cycles when dv_ready is already high.
- ISSUE tolerates dv_ready=0, e.g. the first post-reset divider cycle, by holding dv_valid.
- Simultaneous reqN_flush and reqN_valid in IDLE: no accept.
- Simultaneous flush and dv_ready in ISSUE: flush wins, no issue.
- Simultaneous respN_ready and reqN_flush in RESP: IDLE either way.

## Test plan
- **Basic signed divide:** req0 DIV a=100 b=7 -> resp0_data=14. REM of the same operands -> 2. dv_divw=0, dv_signed=1.
- **Word forms with sign extension:**
  - REMW a=0xFFFFFFFFFFFFFFF9 (-7) b=2 -> 0xFFFFFFFFFFFFFFFF.
  - DIVUW a=0x0000000080000000 b=1 -> 0xFFFFFFFF80000000.
- **Special cases (each with respN_valid exactly 1 cycle after accept and dv_valid never high):**
  - DIVU a=5 b=0 -> 0xFFFFFFFFFFFFFFFF.
  - REM a=5 b=0 -> 5.
  - DIV a=0x8000000000000000 b=-1 -> 0x8000000000000000.
  - REMW a=0x80000000 b=-1 -> 0.
- **Arbitration:** req0 and req1 valid together from reset -> req0 served first, then req1. req0 held continuously valid alternates with req1 (round-robin).
- **Flush in WAIT:** req1 flush mid-WAIT -> dv_flush pulses 1 cycle, no resp1_valid. An immediately following req0 DIV 9/3 -> resp0_data=3.
- **Back-pressure and reset:**
  - resp0_ready=0 for 5 cycles -> resp0_valid and resp0_data held, req1 not accepted.
  - rst_n asserted mid-WAIT -> all outputs 0 immediately, state IDLE.
